// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM pipelined masters share one slave port.
// The owner keeps the bus until it drops cyc; an optional timeout aborts a hung cycle.
module wb_rr_arbiter #(
   parameter int NM  = 4,
   parameter int AW  = 19,
   parameter int DW  = 32,
   parameter int TMO = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NM-1:0]        i_cyc,
   input  logic [NM-1:0]        i_stb,
   input  logic [NM-1:0]        i_we,
   input  logic [NM*AW-1:0]     i_adr,
   input  logic [NM*DW-1:0]     i_dat,
   input  logic [NM*DW/8-1:0]   i_sel,
   output logic [NM-1:0]        o_ack,
   output logic [NM-1:0]        o_stall,
   output logic [NM-1:0]        o_err,
   output logic [NM-1:0]        o_grant,
   output logic                 o_cyc,
   output logic                 o_stb,
   output logic                 o_we,
   output logic [AW-1:0]        o_adr,
   output logic [DW-1:0]        o_dat,
   output logic [DW/8-1:0]      o_sel,
   input  logic                 i_ack,
   input  logic                 i_stall,
   input  logic                 i_err,
   output logic [1:0]           o_state
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = DW / 8;

   // Master side handshake: a beat transfers when o_cyc & o_stb & !o_stall[k];
   // acks/errs are returned only to the current owner while o_cyc is high.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [IW-1:0] r_owner, r_last, win;
   logic          own_cyc, any_req, enter_own, tmo_hit;

   assign own_cyc = i_cyc[r_owner];
   assign any_req = |i_cyc;
   assign o_state = state;

   // Highest offset is visited first so the nearest requester after r_last wins.
   always_comb begin
      int idx;
      win = r_last;
      idx = 0;
      for (int i = NM; i >= 1; i--) begin
         idx = (int'(r_last) + i) % NM;
         if (i_cyc[idx[IW-1:0]]) win = idx[IW-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         r_owner <= '0;
         r_last  <= IW'(NM - 1);
      end else begin
         state <= state_nx;
         if (enter_own) begin
            r_owner <= win;
            r_last  <= win;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      enter_own = 1'b0;
      o_cyc     = 1'b0;
      o_stb     = 1'b0;
      o_ack     = '0;
      o_err     = '0;
      o_stall   = '1;
      o_grant   = '0;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               state_nx  = S_OWN;
               enter_own = 1'b1;
            end
         end
         S_OWN: begin
            o_grant[r_owner] = 1'b1;
            o_stall[r_owner] = i_stall;
            if (!own_cyc) begin
               if (any_req) enter_own = 1'b1;
               else         state_nx  = S_IDLE;
            end else if (tmo_hit && !i_ack && !i_err) begin
               o_err[r_owner] = 1'b1;
               state_nx       = S_ABORT;
            end else begin
               o_cyc          = 1'b1;
               o_stb          = i_stb[r_owner];
               o_ack[r_owner] = i_ack;
               o_err[r_owner] = i_err;
            end
         end
         S_ABORT: begin
            o_grant[r_owner] = 1'b1;
            if (!own_cyc) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign o_we  = i_we[r_owner];
   assign o_adr = i_adr[int'(r_owner)*AW +: AW];
   assign o_dat = i_dat[int'(r_owner)*DW +: DW];
   assign o_sel = i_sel[int'(r_owner)*SW +: SW];

   generate
      if (TMO > 0) begin : g_tmo
         localparam int TW = $clog2(TMO + 1);
         logic [TW-1:0] r_tmo;

         // Counts owned bus clocks since the last ack/err; saturates at TMO-1 because o_cyc drops there.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)                          r_tmo <= '0;
            else if (enter_own || i_ack || i_err)  r_tmo <= '0;
            else if (state == S_OWN && o_cyc)      r_tmo <= r_tmo + 1'b1;
         end

         assign tmo_hit = (r_tmo == TW'(TMO - 1));
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_wb_rr_arbiter;

   localparam int NM  = 4;
   localparam int AW  = 19;
   localparam int DW  = 32;
   localparam int TMO = 8;
   localparam int SW  = DW / 8;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic [NM-1:0]     i_cyc, i_stb, i_we;
   logic [NM*AW-1:0]  i_adr;
   logic [NM*DW-1:0]  i_dat;
   logic [NM*SW-1:0]  i_sel;
   logic [NM-1:0]     o_ack, o_stall, o_err, o_grant;
   logic              o_cyc, o_stb, o_we;
   logic [AW-1:0]     o_adr;
   logic [DW-1:0]     o_dat;
   logic [SW-1:0]     o_sel;
   logic              i_ack, i_stall, i_err;
   logic [1:0]        o_state;

   int n_checks = 0;
   int n_errors = 0;

   wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TMO(TMO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
      .i_adr(i_adr), .i_dat(i_dat), .i_sel(i_sel),
      .o_ack(o_ack), .o_stall(o_stall), .o_err(o_err), .o_grant(o_grant),
      .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
      .o_adr(o_adr), .o_dat(o_dat), .o_sel(o_sel),
      .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err),
      .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   // Model: phase 0 = no owner, 1 = owner on the bus, 2 = owner aborted.
   int m_phase, m_owner, m_last, m_quiet;
   logic          e_cyc, e_stb, e_fire;
   logic [NM-1:0] e_ack, e_err, e_stall, e_grant;
   logic [AW+DW+SW:0] e_bus;

   function automatic int rr_pick(int last, logic [NM-1:0] req);
      int pick;
      pick = -1;
      for (int off = 1; off <= NM; off++)
         if (pick < 0 && req[(last + off) % NM]) pick = (last + off) % NM;
      return pick;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_last = NM - 1; m_quiet = 0;
   endtask

   task automatic model_eval();
      e_cyc = 1'b0; e_stb = 1'b0; e_fire = 1'b0;
      e_ack = '0; e_err = '0; e_stall = '1; e_grant = '0;
      e_bus = {i_we[m_owner], i_adr[m_owner*AW +: AW], i_dat[m_owner*DW +: DW], i_sel[m_owner*SW +: SW]};
      if (m_phase != 0) e_grant[m_owner] = 1'b1;
      if (m_phase == 1) begin
         e_stall[m_owner] = i_stall;
         if (i_cyc[m_owner]) begin
            e_fire = (m_quiet == TMO - 1) && !i_ack && !i_err;
            if (e_fire) e_err[m_owner] = 1'b1;
            else begin
               e_cyc = 1'b1;
               e_stb = i_stb[m_owner];
               e_ack[m_owner] = i_ack;
               e_err[m_owner] = i_err;
            end
         end
      end
   endtask

   task automatic model_step();
      if (!i_rst_n) begin
         model_reset();
         return;
      end
      model_eval();
      case (m_phase)
         0: if (|i_cyc) begin
               m_owner = rr_pick(m_last, i_cyc); m_last = m_owner; m_phase = 1; m_quiet = 0;
            end
         1: if (!i_cyc[m_owner]) begin
               if (|i_cyc) begin
                  m_owner = rr_pick(m_last, i_cyc); m_last = m_owner; m_quiet = 0;
               end else m_phase = 0;
            end else if (e_fire) m_phase = 2;
            else if (i_ack || i_err) m_quiet = 0;
            else m_quiet++;
         default: if (!i_cyc[m_owner]) m_phase = 0;
      endcase
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic drive_quiet();
      i_cyc = '0; i_stb = '0; i_we = '0; i_ack = 1'b0; i_stall = 1'b0; i_err = 1'b0;
   endtask

   task automatic do_reset();
      drive_quiet();
      i_rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive_quiet();
      i_adr = '0; i_dat = '0; i_sel = '0;
      model_reset();
      #2;
      n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL reset_cyc: got %b want 0", o_cyc); end
      n_checks++; if (o_stb !== 1'b0) begin n_errors++; $display("FAIL reset_stb: got %b want 0", o_stb); end
      n_checks++; if (o_ack !== 4'h0) begin n_errors++; $display("FAIL reset_ack: got %h want 0", o_ack); end
      n_checks++; if (o_err !== 4'h0) begin n_errors++; $display("FAIL reset_err: got %h want 0", o_err); end
      n_checks++; if (o_grant !== 4'h0) begin n_errors++; $display("FAIL reset_grant: got %h want 0", o_grant); end
      n_checks++; if (o_stall !== 4'hf) begin n_errors++; $display("FAIL reset_stall: got %h want f", o_stall); end
      n_checks++; if (o_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_rr_order();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [NM-1:0] exp_g;
      do_reset();
      i_cyc = '1; i_stb = '1;
      @(negedge i_clk);
      n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL rr_idle_cyc: got %b want 0", o_cyc); end
      tick();
      for (int g = 0; g < 5; g++) begin
         exp_g = '0; exp_g[order[g]] = 1'b1;
         i_cyc = '1; i_ack = 1'b1;
         @(negedge i_clk);
         n_checks++; if (o_cyc !== 1'b1) begin n_errors++; $display("FAIL rr_cyc[%0d]: got %b want 1", g, o_cyc); end
         n_checks++; if (o_grant !== exp_g) begin n_errors++; $display("FAIL rr_grant[%0d]: got %h want %h", g, o_grant, exp_g); end
         n_checks++; if (o_ack !== exp_g) begin n_errors++; $display("FAIL rr_ack[%0d]: got %h want %h", g, o_ack, exp_g); end
         tick();
         i_cyc = ~exp_g; i_ack = 1'b0;
         @(negedge i_clk);
         n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL rr_gap[%0d]: got %b want 0", g, o_cyc); end
         tick();
      end
   endtask

   task automatic test_stall_other();
      do_reset();
      i_cyc = 4'b0100; i_stb = 4'b0100;
      tick();
      for (int c = 0; c < 3; c++) begin
         i_cyc = 4'b0101; i_stb = 4'b0101; i_ack = 1'b1;
         @(negedge i_clk);
         n_checks++; if (o_grant !== 4'b0100) begin n_errors++; $display("FAIL so_grant[%0d]: got %h want 4", c, o_grant); end
         n_checks++; if (o_stall[0] !== 1'b1) begin n_errors++; $display("FAIL so_stall0[%0d]: got %b want 1", c, o_stall[0]); end
         n_checks++; if (o_ack !== 4'b0100) begin n_errors++; $display("FAIL so_ack[%0d]: got %h want 4", c, o_ack); end
         tick();
      end
      i_cyc = 4'b0001; i_stb = 4'b0001; i_ack = 1'b0;
      @(negedge i_clk);
      n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL so_drop_cyc: got %b want 0", o_cyc); end
      tick();
      @(negedge i_clk);
      n_checks++; if (o_cyc !== 1'b1) begin n_errors++; $display("FAIL so_m0_cyc: got %b want 1", o_cyc); end
      n_checks++; if (o_grant !== 4'b0001) begin n_errors++; $display("FAIL so_m0_grant: got %h want 1", o_grant); end
      tick();
   endtask

   task automatic test_burst();
      logic [7:0] stb_tab, stall_tab, ack_tab;
      int acks;
      stb_tab = 8'b0001_1111; stall_tab = 8'b0000_1001; ack_tab = 8'b0110_1100;
      acks = 0;
      do_reset();
      for (int k = 0; k < NM; k++) begin
         i_adr[k*AW +: AW] = AW'($urandom()); i_dat[k*DW +: DW] = $urandom(); i_sel[k*SW +: SW] = SW'($urandom());
      end
      i_cyc = 4'b1000;
      @(negedge i_clk);
      n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL bu_req_cyc: got %b want 0", o_cyc); end
      tick();
      for (int c = 0; c < 8; c++) begin
         i_stb = {stb_tab[c], 3'b000}; i_stall = stall_tab[c]; i_ack = ack_tab[c];
         @(negedge i_clk);
         if (c == 0) begin
            n_checks++; if (o_cyc !== 1'b1) begin n_errors++; $display("FAIL bu_grant_cyc: got %b want 1", o_cyc); end
            n_checks++; if (o_grant !== 4'b1000) begin n_errors++; $display("FAIL bu_grant: got %h want 8", o_grant); end
            n_checks++; if (o_adr !== i_adr[3*AW +: AW]) begin n_errors++; $display("FAIL bu_adr: got %h want %h", o_adr, i_adr[3*AW +: AW]); end
         end
         n_checks++; if (o_stall !== {stall_tab[c], 3'b111}) begin n_errors++; $display("FAIL bu_stall[%0d]: got %h want %h", c, o_stall, {stall_tab[c], 3'b111}); end
         n_checks++; if (o_ack[2:0] !== 3'b000) begin n_errors++; $display("FAIL bu_ack_other[%0d]: got %h want 0", c, o_ack); end
         if (o_ack[3] === 1'b1) acks++;
         tick();
      end
      n_checks++; if (acks != 4) begin n_errors++; $display("FAIL bu_ack_count: got %0d want 4", acks); end
      drive_quiet();
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      i_cyc = 4'b0010; i_stb = 4'b0010;
      tick();
      for (int c = 1; c <= 8; c++) begin
         @(negedge i_clk);
         if (c < 8) begin
            n_checks++; if (o_cyc !== 1'b1 || o_err !== 4'h0) begin n_errors++; $display("FAIL to_own[%0d]: got cyc %b err %h want 1/0", c, o_cyc, o_err); end
         end else begin
            n_checks++; if (o_err !== 4'b0010) begin n_errors++; $display("FAIL to_err: got %h want 2", o_err); end
            n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL to_cyc: got %b want 0", o_cyc); end
         end
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         i_ack = 1'b1;
         @(negedge i_clk);
         n_checks++; if (o_state !== 2'd2) begin n_errors++; $display("FAIL to_abort_state[%0d]: got %0d want 2", c, o_state); end
         n_checks++; if (o_cyc !== 1'b0 || o_ack !== 4'h0 || o_err !== 4'h0) begin n_errors++; $display("FAIL to_abort_quiet[%0d]: got cyc %b ack %h err %h want 0", c, o_cyc, o_ack, o_err); end
         n_checks++; if (o_stall !== 4'hf || o_grant !== 4'b0010) begin n_errors++; $display("FAIL to_abort_stall[%0d]: got stall %h grant %h want f/2", c, o_stall, o_grant); end
         tick();
      end
      i_cyc = '0; i_stb = '0; i_ack = 1'b0;
      tick();
      @(negedge i_clk);
      n_checks++; if (o_state !== 2'd0 || o_grant !== 4'h0) begin n_errors++; $display("FAIL to_idle: got state %0d grant %h want 0/0", o_state, o_grant); end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      i_cyc = 4'b0001; i_stb = 4'b0001;
      tick();
      @(negedge i_clk);
      n_checks++; if (o_cyc !== 1'b1) begin n_errors++; $display("FAIL ar_active: got %b want 1", o_cyc); end
      #1;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (o_cyc !== 1'b0) begin n_errors++; $display("FAIL ar_cyc: got %b want 0", o_cyc); end
      n_checks++; if (o_stall !== 4'hf || o_grant !== 4'h0) begin n_errors++; $display("FAIL ar_stall: got stall %h grant %h want f/0", o_stall, o_grant); end
      tick();
      tick();
      i_rst_n = 1'b1;
      i_cyc = 4'b0110; i_stb = 4'b0110;
      tick();
      @(negedge i_clk);
      n_checks++; if (o_grant !== 4'b0010 || o_cyc !== 1'b1) begin n_errors++; $display("FAIL ar_first_grant: got grant %h cyc %b want 2/1", o_grant, o_cyc); end
      tick();
      drive_quiet();
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < NM; k++) begin
            if ($urandom_range(0, 5) == 0) i_cyc[k] = ~i_cyc[k];
            i_adr[k*AW +: AW] = AW'($urandom());
            i_dat[k*DW +: DW] = $urandom();
            i_sel[k*SW +: SW] = SW'($urandom());
         end
         i_stb = NM'($urandom()); i_we = NM'($urandom());
         i_ack = ($urandom_range(0, 7) == 0);
         i_err = ($urandom_range(0, 31) == 0);
         i_stall = ($urandom_range(0, 3) == 0);
         @(negedge i_clk);
         model_eval();
         n_checks++; if (o_cyc !== e_cyc || o_stb !== e_stb) begin n_errors++; $display("FAIL rnd_cyc_stb[%0d]: got %b%b want %b%b", n, o_cyc, o_stb, e_cyc, e_stb); end
         n_checks++; if (o_ack !== e_ack || o_err !== e_err) begin n_errors++; $display("FAIL rnd_ack_err[%0d]: got %h/%h want %h/%h", n, o_ack, o_err, e_ack, e_err); end
         n_checks++; if (o_stall !== e_stall || o_grant !== e_grant) begin n_errors++; $display("FAIL rnd_stall_grant[%0d]: got %h/%h want %h/%h", n, o_stall, o_grant, e_stall, e_grant); end
         if (e_cyc) begin
            n_checks++; if ({o_we, o_adr, o_dat, o_sel} !== e_bus) begin n_errors++; $display("FAIL rnd_bus[%0d]: got %h want %h", n, {o_we, o_adr, o_dat, o_sel}, e_bus); end
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rr_order();
      test_stall_other();
      test_burst();
      test_timeout();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
